// File: rtl/scratchpad_access_arbiter_pkg.sv
// Shared types and helpers for the scratchpad access arbiter.
package scratchpad_arb_pkg;

  localparam int DEF_NUM_REQ    = 3;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 64;

  // Transaction FSM encoding: IDLE -> ISSUE -> RESP -> IDLE.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_RESP  = 2'd2;

  // Width of an encoded requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scratchpad_access_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request strictly after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);

  // Two ascending passes: indices above ptr first, then the wrapped ones
  // (0..ptr). The first hit in that order is the round-robin winner.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (en && !any && req[i] && (IW'(i) > ptr)) begin
        gnt[i] = 1'b1;
        idx    = IW'(i);
        any    = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (en && !any && req[i] && (IW'(i) <= ptr)) begin
        gnt[i] = 1'b1;
        idx    = IW'(i);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/scratchpad_access_arbiter.sv
// Serialises scratchpad accesses from several requesters onto one port.
// One access in flight; each takes IDLE/ISSUE/RESP, three cycles.
module scratchpad_access_arbiter
  import scratchpad_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             mem_rst_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ-1:0]               req_write_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata_i,
  input  logic [NUM_REQ*MASK_WIDTH-1:0]    req_mask_i,
  output logic [NUM_REQ-1:0]               rsp_valid_o,
  output logic                             rsp_err_o,
  output logic [DATA_WIDTH-1:0]            rsp_rdata_o,
  output logic                             mem_write_o,
  output logic [ADDR_WIDTH-1:0]            mem_addr_o,
  output logic [DATA_WIDTH-1:0]            mem_wdata_o,
  output logic [MASK_WIDTH-1:0]            mem_mask_o,
  input  logic [DATA_WIDTH-1:0]            mem_rdata_i,
  output logic                             busy_o,
  output logic [id_width(NUM_REQ)-1:0]     grant_id_o
);

  localparam int IW = id_width(NUM_REQ);

  // Per-requester views of the flat request buses (same bit layout).
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_v;
  logic [NUM_REQ-1:0][MASK_WIDTH-1:0] mask_v;

  assign addr_v  = req_addr_i;
  assign wdata_v = req_wdata_i;
  assign mask_v  = req_mask_i;

  state_t                state;
  logic [IW-1:0]         owner;
  logic [IW-1:0]         rr_ptr;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [MASK_WIDTH-1:0] mask_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic                  arb_en;
  logic [NUM_REQ-1:0]    gnt;
  logic [IW-1:0]         win;
  logic                  win_any;

  // Grants only from IDLE and never while the scratchpad is held in reset.
  assign arb_en = (state == ST_IDLE) && !mem_rst_i;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req (req_valid_i),
    .ptr (rr_ptr),
    .en  (arb_en),
    .gnt (gnt),
    .idx (win),
    .any (win_any)
  );

  assign req_ready_o = gnt;

  // FSM, request capture and read-data capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= ST_IDLE;
      owner   <= '0;
      rr_ptr  <= IW'(NUM_REQ - 1);
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_any) begin
            // Latched here so a requester may drop valid right after ready.
            write_q <= req_write_i[win];
            addr_q  <= addr_v[win];
            wdata_q <= wdata_v[win];
            mask_q  <= mask_v[win];
            owner   <= win;
            rr_ptr  <= win;
            err_q   <= 1'b0;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Writes and aborted accesses return zero data.
          rdata_q <= (write_q || mem_rst_i) ? '0 : mem_rdata_i;
          err_q   <= mem_rst_i;
          state   <= ST_RESP;
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Scratchpad port: address held across ISSUE and RESP, strobe and mask
  // only in ISSUE and only for a write not cut off by a memory reset.
  always_comb begin
    mem_write_o = (state == ST_ISSUE) && write_q && !mem_rst_i;
    mem_addr_o  = (state == ST_IDLE) ? '0 : addr_q;
    mem_wdata_o = (state == ST_ISSUE) ? wdata_q : '0;
    mem_mask_o  = mem_write_o ? mask_q : '0;
  end

  // Completion pulse to the owner; an abort forces the error flag and zero data.
  always_comb begin
    rsp_valid_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((state == ST_RESP) && (owner == IW'(i))) rsp_valid_o[i] = 1'b1;
    end
    rsp_err_o   = (state == ST_RESP) && (err_q || mem_rst_i);
    rsp_rdata_o = ((state == ST_RESP) && !rsp_err_o) ? rdata_q : '0;
  end

  assign busy_o     = (state != ST_IDLE);
  assign grant_id_o = owner;

endmodule

// File: tb/tb_scratchpad_access_arbiter.sv
// Directed bench for scratchpad_access_arbiter with a byte-masked RAM model.
module tb_scratchpad_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_rst;
  logic [2:0]  req_valid, req_ready, req_write, rsp_valid;
  logic [95:0] req_addr;
  logic [191:0] req_wdata;
  logic [23:0] req_mask;
  logic        rsp_err, mem_write, busy;
  logic [63:0] rsp_rdata, mem_wdata, mem_rdata;
  logic [31:0] mem_addr;
  logic [7:0]  mem_mask;
  logic [1:0]  grant_id;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  scratchpad_access_arbiter #(
    .NUM_REQ(3), .ADDR_WIDTH(32), .DATA_WIDTH(64), .MASK_WIDTH(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .mem_rst_i(mem_rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_mask_i(req_mask),
    .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err), .rsp_rdata_o(rsp_rdata),
    .mem_write_o(mem_write), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_mask_o(mem_mask), .mem_rdata_i(mem_rdata), .busy_o(busy),
    .grant_id_o(grant_id)
  );

  // RAM model: word index = addr[12:3]; preload word i = C0DE_0000_0000_0000 | i.
  logic [63:0] ram [0:1023];
  bit          ram_ok;
  always @(posedge clk) begin
    if (!ram_ok) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 64'hC0DE_0000_0000_0000 | 64'(i);
      ram_ok <= 1'b1;
    end else if (mem_write) begin
      for (int b = 0; b < 8; b++)
        if (mem_mask[b]) ram[mem_addr[12:3]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end
  assign mem_rdata = ram[mem_addr[12:3]];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  valid;
    logic [2:0]  write;
    logic [31:0] addr1;
    logic [63:0] wdata1;
    logic [7:0]  mask1;
    logic        mrst;
    logic [2:0]  e_ready;
    logic        e_mw;
    logic [31:0] e_addr;
    logic [63:0] e_wdata;
    logic [7:0]  e_mask;
    logic [2:0]  e_rsp;
    logic        e_err;
    logic [63:0] e_rdata;
    logic        e_busy;
    logic [1:0]  e_gid;
  } vec_t;

  function automatic vec_t mk(
    input logic [2:0] valid, input logic [2:0] write, input logic [31:0] addr1,
    input logic [63:0] wdata1, input logic [7:0] mask1, input logic mrst,
    input logic [2:0] e_ready, input logic e_mw, input logic [31:0] e_addr,
    input logic [63:0] e_wdata, input logic [7:0] e_mask, input logic [2:0] e_rsp,
    input logic e_err, input logic [63:0] e_rdata, input logic e_busy, input logic [1:0] e_gid);
    vec_t v;
    v.valid = valid; v.write = write; v.addr1 = addr1; v.wdata1 = wdata1;
    v.mask1 = mask1; v.mrst = mrst; v.e_ready = e_ready; v.e_mw = e_mw;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_mask = e_mask; v.e_rsp = e_rsp;
    v.e_err = e_err; v.e_rdata = e_rdata; v.e_busy = e_busy; v.e_gid = e_gid;
    return v;
  endfunction

  localparam logic [31:0] A  = 32'h8000_0010;
  localparam logic [63:0] D  = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] WD = 64'h1234_5678_9ABC_DEF0;

  vec_t tbl [15];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int first_acc, last_id, last_acc, max_gap, c0, c2, bad, alt_bad, id;

    // Round-robin reads (0x100/0x108/0x110), then write-then-read by req1.
    tbl[0]  = mk(3'b111, 3'b000, 32'h108, 0, 0, 0,  3'b001, 0, 32'h0,   0, 0,     3'b000, 0, 0, 0, 2'd0);
    tbl[1]  = mk(3'b110, 3'b000, 32'h108, 0, 0, 0,  3'b000, 0, 32'h100, 0, 0,     3'b000, 0, 0, 1, 2'd0);
    tbl[2]  = mk(3'b110, 3'b000, 32'h108, 0, 0, 0,  3'b000, 0, 32'h100, 0, 0,     3'b001, 0, 64'hC0DE_0000_0000_0020, 1, 2'd0);
    tbl[3]  = mk(3'b110, 3'b000, 32'h108, 0, 0, 0,  3'b010, 0, 32'h0,   0, 0,     3'b000, 0, 0, 0, 2'd0);
    tbl[4]  = mk(3'b100, 3'b000, 32'h108, 0, 0, 0,  3'b000, 0, 32'h108, 0, 0,     3'b000, 0, 0, 1, 2'd1);
    tbl[5]  = mk(3'b100, 3'b000, 32'h108, 0, 0, 0,  3'b000, 0, 32'h108, 0, 0,     3'b010, 0, 64'hC0DE_0000_0000_0021, 1, 2'd1);
    tbl[6]  = mk(3'b100, 3'b000, 32'h108, 0, 0, 0,  3'b100, 0, 32'h0,   0, 0,     3'b000, 0, 0, 0, 2'd1);
    tbl[7]  = mk(3'b000, 3'b000, 32'h108, 0, 0, 0,  3'b000, 0, 32'h110, 0, 0,     3'b000, 0, 0, 1, 2'd2);
    tbl[8]  = mk(3'b000, 3'b000, 32'h108, 0, 0, 0,  3'b000, 0, 32'h110, 0, 0,     3'b100, 0, 64'hC0DE_0000_0000_0022, 1, 2'd2);
    tbl[9]  = mk(3'b010, 3'b010, A, D, 8'hFF, 0,    3'b010, 0, 32'h0,   0, 0,     3'b000, 0, 0, 0, 2'd2);
    tbl[10] = mk(3'b000, 3'b000, A, 0, 0, 0,        3'b000, 1, A,       D, 8'hFF, 3'b000, 0, 0, 1, 2'd1);
    tbl[11] = mk(3'b000, 3'b000, A, 0, 0, 0,        3'b000, 0, A,       0, 0,     3'b010, 0, 0, 1, 2'd1);
    tbl[12] = mk(3'b010, 3'b000, A, 0, 0, 0,        3'b010, 0, 32'h0,   0, 0,     3'b000, 0, 0, 0, 2'd1);
    tbl[13] = mk(3'b000, 3'b000, A, 0, 0, 0,        3'b000, 0, A,       0, 0,     3'b000, 0, 0, 1, 2'd1);
    tbl[14] = mk(3'b000, 3'b000, A, 0, 0, 0,        3'b000, 0, A,       0, 0,     3'b010, 0, D, 1, 2'd1);

    rst_n = 1'b0; mem_rst = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",  64'(req_ready), 0);
    check("rst_busy",   64'(busy), 0);
    check("rst_gid",    64'(grant_id), 0);
    check("rst_rsp",    64'(rsp_valid), 0);
    check("rst_maddr",  64'(mem_addr), 0);
    check("rst_mwrite", 64'(mem_write), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    foreach (tbl[r]) begin
      req_valid = tbl[r].valid;
      req_write = tbl[r].write;
      req_addr  = {32'h110, tbl[r].addr1, 32'h100};
      req_wdata = {64'h0, tbl[r].wdata1, 64'h0};
      req_mask  = {8'h0, tbl[r].mask1, 8'h0};
      mem_rst   = tbl[r].mrst;
      @(negedge clk);
      check($sformatf("row%0d_ready", r), 64'(req_ready), 64'(tbl[r].e_ready));
      check($sformatf("row%0d_mwrite", r), 64'(mem_write), 64'(tbl[r].e_mw));
      check($sformatf("row%0d_maddr", r), 64'(mem_addr), 64'(tbl[r].e_addr));
      check($sformatf("row%0d_mwdata", r), mem_wdata, tbl[r].e_wdata);
      check($sformatf("row%0d_mmask", r), 64'(mem_mask), 64'(tbl[r].e_mask));
      check($sformatf("row%0d_rsp", r), 64'(rsp_valid), 64'(tbl[r].e_rsp));
      check($sformatf("row%0d_err", r), 64'(rsp_err), 64'(tbl[r].e_err));
      check($sformatf("row%0d_rdata", r), rsp_rdata, tbl[r].e_rdata);
      check($sformatf("row%0d_busy", r), 64'(busy), 64'(tbl[r].e_busy));
      check($sformatf("row%0d_gid", r), 64'(grant_id), 64'(tbl[r].e_gid));
      tick();
    end

    // Fairness: req0 and req2 valid for 30 cycles.
    req_valid = 3'b101; req_write = '0; req_wdata = '0; req_mask = '0;
    req_addr = {32'h110, 32'h108, 32'h100};
    first_acc = -1; last_id = -1; last_acc = -1; max_gap = 0;
    c0 = 0; c2 = 0; bad = 0; alt_bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (req_ready != 3'b000) begin
        id = (req_ready == 3'b001) ? 0 : (req_ready == 3'b100) ? 2 : 9;
        if (id == 0) c0++; else if (id == 2) c2++; else bad++;
        if (id == last_id) alt_bad++;
        last_id = id;
        if (first_acc < 0) first_acc = c;
        if (last_acc >= 0 && (c - last_acc) > max_gap) max_gap = c - last_acc;
        last_acc = c;
      end
      tick();
    end
    req_valid = '0;
    check("fair_first",  64'(first_acc), 0);
    check("fair_cnt0",   64'(c0), 5);
    check("fair_cnt2",   64'(c2), 5);
    check("fair_alt",    64'(alt_bad), 0);
    check("fair_badgnt", 64'(bad), 0);
    check("fair_gap",    64'(max_gap), 3);

    // Memory reset hold with req0 waiting.
    mem_rst = 1'b1; req_valid = 3'b001;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("mrst_ready%0d", c), 64'(req_ready), 0);
      tick();
    end
    mem_rst = 1'b0;
    @(negedge clk);
    check("mrst_release_ready", 64'(req_ready), 64'(3'b001));
    tick(); req_valid = '0;
    tick();
    @(negedge clk);
    check("mrst_rsp",   64'(rsp_valid), 64'(3'b001));
    check("mrst_rdata", rsp_rdata, 64'hC0DE_0000_0000_0020);
    tick();

    // Abort: req2 write to 0x200 with mem_rst in ISSUE.
    req_addr = {32'h200, 32'h108, 32'h100};
    req_wdata = {WD, 64'h0, 64'h0}; req_mask = {8'hFF, 8'h0, 8'h0};
    req_valid = 3'b100; req_write = 3'b100;
    @(negedge clk);
    check("abort_ready", 64'(req_ready), 64'(3'b100));
    tick(); req_valid = '0; req_write = '0; mem_rst = 1'b1;
    @(negedge clk);
    check("abort_mwrite", 64'(mem_write), 0);
    check("abort_mmask",  64'(mem_mask), 0);
    check("abort_busy",   64'(busy), 1);
    tick(); mem_rst = 1'b0;
    @(negedge clk);
    check("abort_rsp",   64'(rsp_valid), 64'(3'b100));
    check("abort_err",   64'(rsp_err), 1);
    check("abort_rdata", rsp_rdata, 0);
    tick();
    req_valid = 3'b100;
    @(negedge clk);
    check("reread_ready", 64'(req_ready), 64'(3'b100));
    tick(); req_valid = '0;
    tick();
    @(negedge clk);
    check("reread_err",   64'(rsp_err), 0);
    check("reread_rdata", rsp_rdata, 64'hC0DE_0000_0000_0040);
    tick();

    // mem_rst rising during RESP of a req0 read.
    req_valid = 3'b001;
    @(negedge clk);
    check("resp_abort_ready", 64'(req_ready), 64'(3'b001));
    tick(); req_valid = '0;
    tick(); mem_rst = 1'b1;
    @(negedge clk);
    check("resp_abort_rsp",   64'(rsp_valid), 64'(3'b001));
    check("resp_abort_err",   64'(rsp_err), 1);
    check("resp_abort_rdata", rsp_rdata, 0);
    tick(); mem_rst = 1'b0;

    // Async reset dropped mid-RESP of a req1 read.
    req_valid = 3'b010;
    @(negedge clk);
    check("areset_ready", 64'(req_ready), 64'(3'b010));
    tick(); req_valid = '0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("areset_rsp",   64'(rsp_valid), 0);
    check("areset_busy",  64'(busy), 0);
    check("areset_gid",   64'(grant_id), 0);
    check("areset_maddr", 64'(mem_addr), 0);
    check("areset_rdata", rsp_rdata, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    req_valid = 3'b111;
    @(negedge clk);
    check("areset_first_win", 64'(req_ready), 64'(3'b001));
    tick(); req_valid = '0;
    tick();
    @(negedge clk);
    check("areset_post_rsp", 64'(rsp_valid), 64'(3'b001));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scratchpad_access_arbiter.md
Name: scratchpad_access_arbiter

Overview:
Arbitrates single-port scratchpad (main memory) access among NUM_REQ requesters: cosim DPI backdoor, printf buffer drain/clear, program loader. Replaces force/release backdoor accesses with a legal, serialized port mux in front of the scratchpad wrapper's mask/write/address/wdata/rdata signals. Round-robin grant, one 64-bit access in flight, registered read data, and memory-reset awareness.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 64, data word width
MASK_WIDTH, DATA_WIDTH/8, byte-enable width

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
mem_rst_i  in  1  scratchpad in reset (synchronous to clk_i); no grants while high
req_valid_i  in  NUM_REQ  request valid per requester
req_ready_o  out  NUM_REQ  request accepted (one-hot or zero)
req_write_i  in  NUM_REQ  1=write, 0=read
req_addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata_i  in  NUM_REQ*DATA_WIDTH  packed write data
req_mask_i  in  NUM_REQ*MASK_WIDTH  packed byte enables
rsp_valid_o  out  NUM_REQ  one-cycle completion pulse to the owner
rsp_err_o  out  1  completion aborted by mem_rst_i (qualified by rsp_valid_o)
rsp_rdata_o  out  DATA_WIDTH  read data (qualified by rsp_valid_o, read only)
mem_write_o  out  1  scratchpad write strobe
mem_addr_o  out  ADDR_WIDTH  scratchpad address
mem_wdata_o  out  DATA_WIDTH  scratchpad write data
mem_mask_o  out  MASK_WIDTH  scratchpad byte mask
mem_rdata_i  in  DATA_WIDTH  scratchpad read data (valid one cycle after address)
busy_o  out  1  transaction in flight
grant_id_o  out  $clog2(NUM_REQ)  current/last owner

Behaviour:
- Reset (rst_ni low, async): state IDLE; all outputs 0; RR pointer = NUM_REQ-1, so requester 0 wins first.
- FSM IDLE -> ISSUE -> RESP -> IDLE. Each access takes 3 cycles, accept to accept.
- IDLE:
  - mem_rst_i high: req_ready_o=0, no grant.
  - Otherwise, if any valid: the winner is the first valid index after the RR pointer (wrapping modulo NUM_REQ).
  - The winner gets req_ready_o bit high combinationally in that cycle. write/addr/wdata/mask latch into internal regs; grant_id_o updates; RR pointer becomes the winner; next state ISSUE.
- ISSUE:
  - mem_addr_o/mem_wdata_o/mem_mask_o driven from regs.
  - mem_write_o=1 for writes only. Address held for reads.
  - busy_o=1. Next state RESP.
- RESP:
  - rsp_valid_o[owner]=1 for exactly one cycle.
  - Read: rsp_rdata_o = mem_rdata_i captured at the end of ISSUE.
  - Write: rsp_rdata_o=0.
  - mem_write_o=0; mem_addr_o holds. Next state IDLE.
- mem_addr_o/wdata/mask are 0 in IDLE; the mask is 0 whenever mem_write_o=0.
- Requester protocol: valid held until ready. Addr/data are stable while valid. Ready never asserts for a non-valid requester.
- mem_rst_i asserts during ISSUE: the write strobe is suppressed in that cycle and the FSM goes to RESP. RESP then pulses rsp_valid_o with rsp_err_o=1 and rsp_rdata_o=0.
- mem_rst_i asserts during RESP: the completion pulses with rsp_err_o=1 and rdata 0.
- Requester drops valid in the accept cycle: the transaction still completes, because it was latched.
- A single requester continuously valid is granted every 3 cycles. With all requesters valid, the grant order is 0,1,2,0,…; the maximum wait is (NUM_REQ-1)*3 cycles.
- Addresses are not aligned or checked by this block. The low 3 bits pass through unmodified.

Decomposition:
- Package scratchpad_arb_pkg: state enum (IDLE, ISSUE, RESP), ID width function, default width localparams.
- Sub-module rr_arbiter: NUM_REQ-wide round-robin picker.
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant, encoded index, any.
- FSM, request registers and datapath mux stay in the top module.

Test Plan:
- Write then read. Req1 writes addr 0x8000_0010, data 0xDEADBEEF_CAFEF00D, mask 0xFF; then req1 reads the same address.
  - Write: ready at cycle 0, mem_write_o at cycle 1, rsp_valid_o[1] at cycle 2.
  - Read: rsp_rdata_o = 0xDEADBEEF_CAFEF00D with rsp_err_o=0.
- Round-robin. Req0, req1 and req2 assert reads of 0x100, 0x108 and 0x110 in the same cycle.
  - Grants 0,1,2 accepted 3 cycles apart; each rsp_valid_o bit fires once with matching data.
- Fairness under load. Req0 and req2 are continuously valid for 30 cycles.
  - Grants alternate 0,2,0,2,…; exactly 5 grants each; no accept gap exceeds 3 cycles.
- Memory reset hold. mem_rst_i is held high for 10 cycles with req0 valid.
  - req_ready_o stays 0 throughout; grant occurs in the first cycle after mem_rst_i falls.
- Abort mid-access. Req2 writes 0x200; mem_rst_i rises in the ISSUE cycle.
  - mem_write_o stays 0; rsp_valid_o[2]=1 with rsp_err_o=1.
  - A later read of 0x200 returns the prior contents.
- Async reset. rst_ni is dropped mid-RESP.
  - All outputs go to 0 immediately with no rsp pulse; after release, requester 0 wins first.
